// File: rtl/dual_diagonal_backsub_stream.sv
// dual_diagonal_backsub_stream
//   Streaming dual-diagonal back-substitution for the QC-LDPC parity path.
//   Produces p_k = p_{k-1} ^ lambda_k over a block of N words, where p_{-1}
//   is the seed word captured on the first beat of the block.
//
//   Optional feature macro: DDB_ROTATE_SEED_EN
//     defined   : seed is rotated left by (i_cfg_shift mod WIDTH) before use
//     undefined : seed is used as-is, i_cfg_shift is ignored
//
// Ports
//   i_clock, i_reset            clock, synchronous active-high reset
//   i_cfg_num_words             block length N (sampled on first beat)
//   i_cfg_shift                 seed rotation (sampled on first beat)
//   i_in_seed                   p_{-1} (sampled on first beat)
//   i_in_data/valid, o_in_ready upstream lambda stream
//   o_out_data/valid/last,
//   i_out_ready                 downstream parity stream, last = word N-1
//   o_cfg_err                   sticky illegal-length flag
module dual_diagonal_backsub_stream #(
    parameter  int WIDTH     = 16,
    parameter  int MAX_WORDS = 8,
    localparam int CW        = $clog2(MAX_WORDS + 1),
    localparam int SW        = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic             i_clock,
    input  logic             i_reset,
    input  logic [CW-1:0]    i_cfg_num_words,
    input  logic [SW-1:0]    i_cfg_shift,
    input  logic [WIDTH-1:0] i_in_seed,
    input  logic [WIDTH-1:0] i_in_data,
    input  logic             i_in_valid,
    output logic             o_in_ready,
    output logic [WIDTH-1:0] o_out_data,
    output logic             o_out_valid,
    input  logic             i_out_ready,
    output logic             o_out_last,
    output logic             o_cfg_err
);

    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [CW-1:0]    n_q, n_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             out_valid_q, out_valid_d;
    logic             out_last_q, out_last_d;
    logic             cfg_err_q, cfg_err_d;

    logic             accept;
    logic             cfg_bad;
    logic [CW-1:0]    n_first;
    logic [WIDTH-1:0] seed_eff;
    logic [WIDTH-1:0] p_word;
    logic             p_last;

`ifdef DDB_ROTATE_SEED_EN
    // Rotate-left via the upper half of a doubled word shifted left.
    logic [2*WIDTH-1:0] seed_dbl;
    always_comb begin
        seed_dbl = {i_in_seed, i_in_seed} << (int'(i_cfg_shift) % WIDTH);
        seed_eff = seed_dbl[2*WIDTH-1 -: WIDTH];
    end
`else
    logic unused_shift;
    assign unused_shift = ^i_cfg_shift;
    assign seed_eff     = i_in_seed;
`endif

    // Single output register: can take a new word whenever it is empty
    // or being drained this cycle.
    assign o_in_ready = !out_valid_q || i_out_ready;
    assign accept     = i_in_valid && o_in_ready;

    // Illegal lengths run as a full-size block.
    assign cfg_bad = (i_cfg_num_words == '0) || (i_cfg_num_words > CW'(MAX_WORDS));
    assign n_first = cfg_bad ? CW'(MAX_WORDS) : i_cfg_num_words;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        n_d         = n_q;
        acc_d       = acc_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        cfg_err_d   = cfg_err_q;
        p_word      = '0;
        p_last      = 1'b0;

        if (out_valid_q && i_out_ready) out_valid_d = 1'b0;

        if (accept) begin
            if (state_q == S_IDLE) begin
                p_word = seed_eff ^ i_in_data;
                n_d    = n_first;
                if (cfg_bad) cfg_err_d = 1'b1;
                if (n_first == CW'(1)) begin
                    p_last = 1'b1;
                    cnt_d  = '0;
                end else begin
                    cnt_d   = CW'(1);
                    state_d = S_RUN;
                end
            end else begin
                p_word = acc_q ^ i_in_data;
                if (cnt_q == n_q - CW'(1)) begin
                    p_last  = 1'b1;
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            acc_d       = p_word;
            out_data_d  = p_word;
            out_valid_d = 1'b1;
            out_last_d  = p_last;
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            n_q         <= '0;
            acc_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            cfg_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            n_q         <= n_d;
            acc_q       <= acc_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            cfg_err_q   <= cfg_err_d;
        end
    end

    assign o_out_data  = out_data_q;
    assign o_out_valid = out_valid_q;
    assign o_out_last  = out_last_q;
    assign o_cfg_err   = cfg_err_q;

endmodule
